host_bridge: RTL
================

# host_bridge

Bridges the UART byte streams and the analyzer control/memory paths. It sits between the `uart` instance and `core`/`sram_interface`. On the receive side it assembles host bytes into SUMP short (1-byte) and long (5-byte) commands and presents them as `ctl_code`/`ctl_data` pulses. On the transmit side it serializes 32-bit sample words from the memory read stream into UART bytes, skipping disabled byte lanes, and answers the ID query itself.

## Interface
Parameters:
- `MDW`, 32: memory word width; must be 32.
- `TMO`, 50_000: inter-byte timeout in clk cycles while a long command is partial; ≥2.

Ports (reset rst, asynchronous, active-high; clock clk):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous active-high reset.
- `str_rxd_tvalid` in 1: host byte valid.
- `str_rxd_tdata` in 8: host byte.
- `str_rxd_tready` out 1: always 1 (RX never stalls); reset value 1.
- `ctl_code` out 8: command opcode; reset 0.
- `ctl_data` out 32: command argument, 0 for short commands; reset 0.
- `ctl_valid` out 1: one-cycle command strobe; reset 0.
- `err_timeout` out 1: one-cycle pulse on an aborted long command; reset 0.
- `mem_tvalid` in 1: sample word valid.
- `mem_tdata` in MDW: sample word.
- `mem_tkeep` in MDW/8: enabled byte lanes.
- `mem_tready` out 1: word accept; reset 0.
- `str_txd_tvalid` out 1: byte to UART valid; reset 0.
- `str_txd_tdata` out 8: byte to UART; reset 0.
- `str_txd_tready` in 1: UART accepts byte.

## Operation
RX FSM, states IDLE and ARG (2-bit argument counter `n`):
- IDLE, byte with bit7 = 0: `ctl_code` = byte, `ctl_data` = 0, `ctl_valid` pulses the next cycle. Stay in IDLE.
- IDLE, byte with bit7 = 1: latch the opcode, `n` = 0, go to ARG.
- ARG, byte: store it as argument byte `n`, little-endian (the first argument byte lands in `ctl_data[7:0]`).
  - On the 4th byte, pulse `ctl_valid` the next cycle and return to IDLE.
- ARG timeout: the idle counter resets on every byte. When it reaches TMO-1, go to IDLE, pulse `err_timeout`, emit no `ctl_valid`, and drop the partial data.
- `ctl_code`/`ctl_data` hold their last value between strobes.
- Five 0x00 bytes produce five reset strobes; no special handling.

ID reply:
- A short 0x02 also sets `id_pend`.
- A second 0x02 while `id_pend` is set is absorbed; the reply is sent once.

TX FSM, states IDLE, WORD and ID:
- `mem_tready` = (state == IDLE) && !`id_pend`.
- IDLE with `id_pend`: go to ID and send 0x31, 0x41, 0x4C, 0x53 ("1ALS") in order. Clear `id_pend` on entry.
  - `id_pend` has priority over `mem_tvalid`.
- IDLE with a mem handshake: latch the word and keep mask, go to WORD.
  - A keep of 0 consumes the word, sends nothing, and stays in IDLE.
- WORD: present the lowest-index byte whose keep bit is set. On a txd handshake, clear that bit. When no bits remain, go to IDLE.
- AXI-stream rule: once `str_txd_tvalid` is high, `str_txd_tdata` is stable until `str_txd_tready`.
- RX and TX run independently. Simultaneous RX command and TX activity need no arbitration.
- Reset mid-operation: a partial command, held word and pending ID are all discarded.

## Timing
- Short command: byte handshake at cycle N → `ctl_valid` at N+1.
- Long command: 5th byte at N → `ctl_valid` at N+1.
- Mem handshake at N → first byte valid at N+1.
- One byte per cycle with `str_txd_tready` held at 1.
- After the last byte of a word is accepted at N, IDLE at N+1 and the next word is accepted at N+1, so its first byte appears at N+2 (one bubble).
- ID at N → `id_pend` at N+1. If TX is idle, the first ID byte is valid at N+2. If TX is busy, the reply follows the current word.
- Timeout: `err_timeout` fires exactly TMO cycles after the last ARG byte.

## Structure
- Package `host_pkg` holds:
  - `ctl_code_t`;
  - `CMD_LONG_BIT` = 7;
  - opcodes `CMD_RESET` = 8'h00, `CMD_RUN` = 8'h01, `CMD_ID` = 8'h02;
  - `ID_STRING` = 32'h534C4131;
  - RX/TX state enums.
- Sub-module `host_cmd_rx` holds the RX FSM, argument shift register and timeout counter. TX and ID logic stay in `host_bridge`.

## Test plan
- Send 0x01 → one `ctl_valid` with code 0x01, data 0x00000000, one cycle after the byte.
- Send 0xC0 0x78 0x56 0x34 0x12 → `ctl_valid` with code 0xC0, data 0x12345678; no strobe earlier.
- Send 0x81 0xAA, then idle TMO cycles → `err_timeout` pulse, no `ctl_valid`. Then send 0x01 → a normal strobe.
- Word 0xDDCCBBAA with keep 4'b1011 and `str_txd_tready` toggling randomly → bytes AA, BB, DD in order, each held stable while stalled. Keep 4'b0000 → no bytes, word consumed.
- Send 0x02 while a 4-byte word is transmitting, with `mem_tvalid` still high → the word completes, then 31 41 4C 53, then the next word. A second 0x02 sent before the reply starts yields a single reply.
- Assert `rst` mid-word and mid-long-command → all outputs return to reset values, `str_rxd_tready` = 1, and no stale strobe or byte follows.

Source files
------------

// File: rtl/host_bridge_pkg.sv
// host_pkg: shared types and constants for the host bridge.
//   ctl_code_t     - command opcode type
//   CMD_LONG_BIT   - opcode bit that marks a 5-byte (long) command
//   CMD_*          - opcodes the bridge or its neighbours care about
//   ID_STRING      - ID reply, sent least significant byte first ("1ALS")
//   rx_state_t     - receive FSM states
//   tx_state_t     - transmit FSM states
//   lowest_lane()  - index of the lowest set bit in a 4-bit keep mask
package host_pkg;

    typedef logic [7:0] ctl_code_t;

    localparam int          CMD_LONG_BIT = 7;
    localparam ctl_code_t   CMD_RESET    = 8'h00;
    localparam ctl_code_t   CMD_RUN      = 8'h01;
    localparam ctl_code_t   CMD_ID       = 8'h02;
    localparam logic [31:0] ID_STRING    = 32'h534C4131;

    typedef enum logic {
        RX_IDLE,
        RX_ARG
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WORD,
        TX_ID
    } tx_state_t;

    // Returns 0 for an empty mask; callers only use it while a bit is set.
    function automatic logic [1:0] lowest_lane(input logic [3:0] keep);
        lowest_lane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (keep[i]) begin
                lowest_lane = 2'(i);
            end
        end
    endfunction

endpackage

// File: rtl/host_bridge_if.sv
// host_bridge_if: every stream and control signal around the host bridge.
//   str_rxd_*  - host byte stream from the UART receiver
//   ctl_*      - decoded command strobe towards the core
//   err_timeout- aborted long command pulse
//   mem_*      - sample word stream from the memory read path
//   str_txd_*  - byte stream to the UART transmitter
// Modports: master = the bridge itself, slave = its surroundings.
interface host_bridge_if
    import host_pkg::*;
#(
    parameter int MDW = 32
);

    logic             str_rxd_tvalid;
    logic [7:0]       str_rxd_tdata;
    logic             str_rxd_tready;

    ctl_code_t        ctl_code;
    logic [31:0]      ctl_data;
    logic             ctl_valid;
    logic             err_timeout;

    logic             mem_tvalid;
    logic [MDW-1:0]   mem_tdata;
    logic [MDW/8-1:0] mem_tkeep;
    logic             mem_tready;

    logic             str_txd_tvalid;
    logic [7:0]       str_txd_tdata;
    logic             str_txd_tready;

    modport master (
        input  str_rxd_tvalid, str_rxd_tdata,
        output str_rxd_tready,
        output ctl_code, ctl_data, ctl_valid, err_timeout,
        input  mem_tvalid, mem_tdata, mem_tkeep,
        output mem_tready,
        output str_txd_tvalid, str_txd_tdata,
        input  str_txd_tready
    );

    modport slave (
        output str_rxd_tvalid, str_rxd_tdata,
        input  str_rxd_tready,
        input  ctl_code, ctl_data, ctl_valid, err_timeout,
        output mem_tvalid, mem_tdata, mem_tkeep,
        input  mem_tready,
        input  str_txd_tvalid, str_txd_tdata,
        output str_txd_tready
    );

endinterface

// File: rtl/host_bridge_cmd_rx.sv
// host_cmd_rx: assembles host bytes into SUMP short/long commands.
//   clk, rst     - clock, asynchronous active-high reset
//   rxd_valid    - host byte present this cycle (always accepted)
//   rxd_data     - host byte
//   ctl_code     - opcode of the last completed command
//   ctl_data     - argument of the last completed command (0 for short ones)
//   ctl_valid    - one-cycle strobe, the cycle after the final byte
//   err_timeout  - one-cycle pulse when a partial long command is dropped
//   id_req       - combinational: a short ID opcode is being accepted now
module host_cmd_rx
    import host_pkg::*;
#(
    parameter int TMO = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd_valid,
    input  logic [7:0]  rxd_data,
    output ctl_code_t   ctl_code,
    output logic [31:0] ctl_data,
    output logic        ctl_valid,
    output logic        err_timeout,
    output logic        id_req
);

    localparam int CW = $clog2(TMO);
    // The abort edge is taken one count early so err_timeout, being
    // registered, lands exactly TMO cycles after the last byte.
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 2);

    rx_state_t     state, state_next;
    logic [1:0]    n, n_next;
    logic [CW-1:0] idle_cnt, idle_cnt_next;
    ctl_code_t     op, op_next;
    logic [23:0]   arg, arg_next;
    ctl_code_t     code_next;
    logic [31:0]   data_next;
    logic          valid_next;
    logic          tmo_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RX_IDLE;
            n           <= 2'd0;
            idle_cnt    <= '0;
            op          <= '0;
            arg         <= '0;
            ctl_code    <= '0;
            ctl_data    <= '0;
            ctl_valid   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            n           <= n_next;
            idle_cnt    <= idle_cnt_next;
            op          <= op_next;
            arg         <= arg_next;
            ctl_code    <= code_next;
            ctl_data    <= data_next;
            ctl_valid   <= valid_next;
            err_timeout <= tmo_next;
        end
    end

    // Argument bytes shift in from the top, so after three bytes arg holds
    // them little-endian and the fourth byte simply tops the word off.
    always_comb begin
        state_next    = state;
        n_next        = n;
        idle_cnt_next = idle_cnt;
        op_next       = op;
        arg_next      = arg;
        code_next     = ctl_code;
        data_next     = ctl_data;
        valid_next    = 1'b0;
        tmo_next      = 1'b0;
        id_req        = 1'b0;

        case (state)
            RX_IDLE: begin
                if (rxd_valid) begin
                    if (rxd_data[CMD_LONG_BIT]) begin
                        op_next       = rxd_data;
                        n_next        = 2'd0;
                        idle_cnt_next = '0;
                        state_next    = RX_ARG;
                    end else begin
                        code_next  = rxd_data;
                        data_next  = 32'h0;
                        valid_next = 1'b1;
                        id_req     = (rxd_data == CMD_ID);
                    end
                end
            end
            RX_ARG: begin
                if (rxd_valid) begin
                    idle_cnt_next = '0;
                    if (n == 2'd3) begin
                        code_next  = op;
                        data_next  = {rxd_data, arg};
                        valid_next = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        arg_next = {rxd_data, arg[23:8]};
                        n_next   = n + 2'd1;
                    end
                end else if (idle_cnt == TMO_LAST) begin
                    tmo_next   = 1'b1;
                    state_next = RX_IDLE;
                end else begin
                    idle_cnt_next = idle_cnt + CW'(1);
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/host_bridge.sv
// host_bridge: joins the UART byte streams to the analyzer control and
// memory paths. Commands are decoded by host_cmd_rx; this level serializes
// sample words into bytes (skipping disabled lanes) and answers the ID query.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - host_bridge_if master: str_rxd_*, ctl_*, err_timeout,
//              mem_*, str_txd_*
// MDW must be 32: the byte serializer assumes four lanes.
module host_bridge
    import host_pkg::*;
#(
    parameter int MDW = 32,
    parameter int TMO = 50_000
) (
    input  logic          clk,
    input  logic          rst,
    host_bridge_if.master bus
);

    logic id_req;

    // The UART receiver cannot be back-pressured, so RX never stalls.
    assign bus.str_rxd_tready = 1'b1;

    host_cmd_rx #(
        .TMO (TMO)
    ) u_cmd_rx (
        .clk         (clk),
        .rst         (rst),
        .rxd_valid   (bus.str_rxd_tvalid),
        .rxd_data    (bus.str_rxd_tdata),
        .ctl_code    (bus.ctl_code),
        .ctl_data    (bus.ctl_data),
        .ctl_valid   (bus.ctl_valid),
        .err_timeout (bus.err_timeout),
        .id_req      (id_req)
    );

    tx_state_t        tx_state, tx_next;
    logic [MDW-1:0]   word;
    logic [MDW/8-1:0] mask, mask_next;
    logic [1:0]       id_idx, id_idx_next;
    logic             id_pend, id_pend_next;
    logic             mem_ready, mem_ready_next;
    logic             txd_valid;
    logic [7:0]       txd_data;
    logic [1:0]       lane;
    logic [3:0]       lane_bit;
    logic             mem_hs;
    logic             txd_hs;

    assign lane     = lowest_lane(mask);
    assign lane_bit = 4'b0001 << lane;
    assign mem_hs   = bus.mem_tvalid && mem_ready;
    assign txd_hs   = txd_valid && bus.str_txd_tready;

    assign bus.mem_tready     = mem_ready;
    assign bus.str_txd_tvalid = txd_valid;
    assign bus.str_txd_tdata  = txd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            word      <= '0;
            mask      <= '0;
            id_idx    <= 2'd0;
            id_pend   <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            tx_state  <= tx_next;
            mask      <= mask_next;
            id_idx    <= id_idx_next;
            id_pend   <= id_pend_next;
            mem_ready <= mem_ready_next;
            if (tx_state == TX_IDLE && mem_hs) begin
                word <= bus.mem_tdata;
            end
        end
    end

    // The pending ID outranks a waiting word. Presented data only moves on a
    // txd handshake, which keeps the byte stable while the UART stalls.
    // mem_tready is registered from next-cycle values so it equals
    // "TX idle and no ID pending" yet still reads 0 in reset.
    always_comb begin
        tx_next      = tx_state;
        mask_next    = mask;
        id_idx_next  = id_idx;
        id_pend_next = id_pend | id_req;
        txd_valid    = 1'b0;
        txd_data     = 8'h00;

        case (tx_state)
            TX_IDLE: begin
                if (id_pend) begin
                    tx_next      = TX_ID;
                    id_idx_next  = 2'd0;
                    id_pend_next = id_req;
                end else if (mem_hs) begin
                    mask_next = bus.mem_tkeep;
                    if (bus.mem_tkeep != '0) begin
                        tx_next = TX_WORD;
                    end
                end
            end
            TX_WORD: begin
                txd_valid = 1'b1;
                txd_data  = word[8*lane +: 8];
                if (txd_hs) begin
                    mask_next = mask & ~lane_bit;
                    if ((mask & ~lane_bit) == 4'b0000) begin
                        tx_next = TX_IDLE;
                    end
                end
            end
            TX_ID: begin
                txd_valid = 1'b1;
                txd_data  = ID_STRING[8*id_idx +: 8];
                if (txd_hs) begin
                    id_idx_next = id_idx + 2'd1;
                    if (id_idx == 2'd3) begin
                        tx_next = TX_IDLE;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase

        mem_ready_next = (tx_next == TX_IDLE) && !id_pend_next;
    end

endmodule
